// File: rtl/fftstream.sv
// Turns the bit-reverse stage's ce/sync sample stream into a valid/ready stream with a
// frame-last marker. The FFT pipeline cannot stall, so samples go through a small FIFO.
module fftstream #(
    parameter int unsigned LGSIZE = 5,
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned LGFIFO = 2
) (
    input  logic               i_clk,
    input  logic               i_areset_n,
    input  logic               i_ce,
    input  logic [2*WIDTH-1:0] i_sample,
    input  logic               i_sync,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [2*WIDTH-1:0] o_data,
    output logic               o_last,
    output logic               o_overflow,
    output logic               o_syncerr
);

    localparam int unsigned DEPTH = 1 << LGFIFO;
    localparam logic [LGSIZE-1:0] IDX_MAX = '1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [LGSIZE-1:0] idx_q, idx_d;
    logic [LGFIFO:0]   wptr_q, rptr_q;
    logic              overflow_q, syncerr_q;
    logic [2*WIDTH:0]  mem [DEPTH];

    logic push, push_last, syncerr_set;
    logic full, empty, pop, wr_en;
    logic [2*WIDTH:0] head;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        push        = 1'b0;
        push_last   = 1'b0;
        syncerr_set = 1'b0;
        if (i_ce) begin
            unique case (state_q)
                StIdle: begin
                    if (i_sync) begin
                        push    = 1'b1;
                        idx_d   = LGSIZE'(1);
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (i_sync) begin
                        // A sync anywhere restarts the frame; off-index syncs are flagged.
                        syncerr_set = (idx_q != '0);
                        push        = 1'b1;
                        idx_d       = LGSIZE'(1);
                    end else if (idx_q == '0) begin
                        syncerr_set = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        push      = 1'b1;
                        push_last = (idx_q == IDX_MAX);
                        idx_d     = idx_q + LGSIZE'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[LGFIFO] != rptr_q[LGFIFO]) &&
                   (wptr_q[LGFIFO-1:0] == rptr_q[LGFIFO-1:0]);
    assign pop   = !empty && i_ready;
    // Full is judged before this cycle's pop, so a simultaneous pop never makes room.
    assign wr_en = push && !full;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            syncerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (wr_en) begin
                wptr_q <= wptr_q + (LGFIFO+1)'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + (LGFIFO+1)'(1);
            end
            if (push && full) begin
                overflow_q <= 1'b1;
            end
            if (syncerr_set) begin
                syncerr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wptr_q[LGFIFO-1:0]] <= {push_last, i_sample};
        end
    end

    assign head       = mem[rptr_q[LGFIFO-1:0]];
    assign o_valid    = !empty;
    assign o_data     = head[2*WIDTH-1:0];
    assign o_last     = !empty && head[2*WIDTH];
    assign o_overflow = overflow_q;
    assign o_syncerr  = syncerr_q;

endmodule

// File: tb/tb_fftstream.sv
// Bench for fftstream: directed frame scenarios then random traffic, all checked against a
// queue-based reference model of the stream.
module tb_fftstream;

    localparam int unsigned LGSIZE = 3;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned LGFIFO = 2;
    localparam int unsigned FRAME  = 1 << LGSIZE;
    localparam int unsigned DEPTH  = 1 << LGFIFO;
    localparam int unsigned DW     = 2 * WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic [DW-1:0] sample = '0;
    logic          sync = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          overflow;
    logic          syncerr;

    fftstream #(
        .LGSIZE(LGSIZE),
        .WIDTH (WIDTH),
        .LGFIFO(LGFIFO)
    ) dut (
        .i_clk     (clk),
        .i_areset_n(rst_n),
        .i_ce      (ce),
        .i_sample  (sample),
        .i_sync    (sync),
        .i_ready   (ready),
        .o_valid   (valid),
        .o_data    (data),
        .o_last    (last),
        .o_overflow(overflow),
        .o_syncerr (syncerr)
    );

    always #5 clk = ~clk;

    // Reference model: alignment flag, frame index, expected FIFO contents, sticky flags.
    bit            m_run;
    int unsigned   m_idx;
    logic [DW:0]   mq[$];
    bit            m_ovf;
    bit            m_serr;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_idx  = 0;
        mq     = {};
        m_ovf  = 1'b0;
        m_serr = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 64'(valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, ".data"}, 64'(data), 64'(mq[0][DW-1:0]));
            chk({tag, ".last"}, 64'(last), 64'(mq[0][DW]));
        end else begin
            chk({tag, ".last"}, 64'(last), 64'd0);
        end
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".syncerr"}, 64'(syncerr), 64'(m_serr));
    endtask

    // One clock: drive inputs, advance the model, then check #1 after the edge.
    task automatic step(input string tag, input bit s_ce, input bit s_sync,
                        input logic [DW-1:0] s_data, input bit s_rdy);
        bit pop, full, push, lst;
        ce     = s_ce;
        sync   = s_sync;
        sample = s_data;
        ready  = s_rdy;
        pop  = (mq.size() != 0) && s_rdy;
        full = (mq.size() == DEPTH);
        push = 1'b0;
        lst  = 1'b0;
        if (s_ce) begin
            if (!m_run) begin
                if (s_sync) begin
                    push  = 1'b1;
                    m_run = 1'b1;
                    m_idx = 1;
                end
            end else if (s_sync) begin
                if (m_idx != 0) m_serr = 1'b1;
                push  = 1'b1;
                m_idx = 1;
            end else if (m_idx == 0) begin
                m_serr = 1'b1;
                m_run  = 1'b0;
            end else begin
                push  = 1'b1;
                lst   = (m_idx == FRAME - 1);
                m_idx = (m_idx + 1) % FRAME;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (full) m_ovf = 1'b1;
            else mq.push_back({lst, s_data});
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_valid"}, 64'(valid), 64'd0);
        chk({tag, ".rst_last"}, 64'(last), 64'd0);
        chk({tag, ".rst_ovf"}, 64'(overflow), 64'd0);
        chk({tag, ".rst_serr"}, 64'(syncerr), 64'd0);
        model_reset();
        ce = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned nom;
        bit rs;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned frames, continuous ce, ready held high.
        for (int i = 0; i < 16; i++) step("frames", 1'b1, (i % FRAME) == 0, DW'(i), 1'b1);
        step("frames_drain", 1'b0, 1'b0, '0, 1'b1);
        chk("frames_ovf", 64'(overflow), 64'd0);
        chk("frames_serr", 64'(syncerr), 64'd0);

        // Unaligned samples before the first sync are discarded.
        do_reset("r1");
        for (int i = 100; i < 103; i++) step("presync", 1'b1, 1'b0, DW'(i), 1'b1);
        chk("presync_valid", 64'(valid), 64'd0);
        step("firstsync", 1'b1, 1'b1, DW'(103), 1'b1);
        chk("firstsync_data", 64'(data), 64'd103);
        for (int i = 104; i < 111; i++) step("presync_tail", 1'b1, 1'b0, DW'(i), 1'b1);

        // Overflow with ready low, drain, then later o_last still on index 7.
        do_reset("r2");
        for (int i = 0; i < 6; i++) begin
            step("ovf", 1'b1, i == 0, DW'(i), 1'b0);
            if (i == 4) chk("ovf_after_5th", 64'(overflow), 64'd1);
        end
        for (int i = 0; i < 4; i++) step("ovf_drain", 1'b0, 1'b0, '0, 1'b1);
        chk("ovf_empty", 64'(valid), 64'd0);
        for (int i = 6; i < 8 + FRAME; i++) step("ovf_next", 1'b1, (i % FRAME) == 0, DW'(i), 1'b1);
        step("ovf_end", 1'b0, 1'b0, '0, 1'b1);

        // Early sync realigns the frame.
        do_reset("r3");
        for (int i = 0; i < 5; i++) step("early", 1'b1, i == 0, DW'(i), 1'b1);
        step("early_sync", 1'b1, 1'b1, DW'(5), 1'b1);
        chk("early_serr", 64'(syncerr), 64'd1);
        for (int i = 6; i < 13; i++) step("early_tail", 1'b1, 1'b0, DW'(i), 1'b1);
        chk("early_last12", 64'(last), 64'd1);

        // Missing sync at index 0 drops to IDLE until the next sync.
        do_reset("r4");
        for (int i = 0; i < FRAME; i++) step("miss", 1'b1, i == 0, DW'(i), 1'b1);
        step("miss_idx0", 1'b1, 1'b0, DW'(8), 1'b1);
        chk("miss_serr", 64'(syncerr), 64'd1);
        step("miss_idle", 1'b1, 1'b0, DW'(9), 1'b1);
        chk("miss_dropped", 64'(valid), 64'd0);
        for (int i = 10; i < 10 + FRAME; i++) step("miss_resync", 1'b1, i == 10, DW'(i), 1'b1);

        // Reset mid-frame with entries queued and syncerr set.
        do_reset("r5");
        step("mid_a", 1'b1, 1'b1, DW'(20), 1'b0);
        step("mid_b", 1'b1, 1'b1, DW'(21), 1'b0);
        step("mid_c", 1'b1, 1'b0, DW'(22), 1'b0);
        chk("mid_serr", 64'(syncerr), 64'd1);
        do_reset("r6");
        for (int i = 0; i < FRAME; i++) step("post_rst", 1'b1, i == 0, DW'(30 + i), 1'b1);

        // Random traffic with occasional sync glitches and back-pressure.
        do_reset("r7");
        nom = 0;
        for (int i = 0; i < 600; i++) begin
            bit rce;
            rce = ($urandom_range(3) != 0);
            rs  = 1'b0;
            if (rce) begin
                rs = (nom == 0);
                if ($urandom_range(19) == 0) rs = !rs;
                nom = (nom + 1) % FRAME;
            end
            step("rand", rce, rs, DW'($urandom), $urandom_range(4) > 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fftstream.md
# fftstream

Converts the clock-enable/sync output of the pipelined FFT's bit-reverse stage into a valid/ready stream with a frame-last marker. Sits directly downstream of the bit-reverse stage, at the FFT core boundary. The FFT pipeline has no back-pressure, so the block buffers through a small FIFO and reports overflow and frame-alignment errors as sticky flags.

## Interface
- LGSIZE, 5: log2 of FFT length; frame = 2^LGSIZE samples.
- WIDTH, 24: bits per real/imag component; sample = 2*WIDTH bits.
- LGFIFO, 2: log2 of FIFO depth (depth 2^LGFIFO entries), LGFIFO >= 1.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_areset_n  in  1  reset, asynchronous and active-low.
- i_ce  in  1  sample strobe from bit-reverse stage.
- i_sample  in  2*WIDTH  complex sample {real, imag}, valid when i_ce.
- i_sync  in  1  first sample of a frame, qualified by i_ce.
- i_ready  in  1  downstream accepts the head word this cycle.
- o_valid  out  1  FIFO non-empty; head word presented.
- o_data  out  2*WIDTH  head sample.
- o_last  out  1  head sample is index 2^LGSIZE-1 of its frame.
- o_overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- o_syncerr  out  1  sticky: i_sync seen at the wrong index, or missing at index 0.

## Operation
- States: IDLE (discard until aligned) and RUN (aligned, counting).
- Index counter idx, LGSIZE bits, counts accepted samples modulo 2^LGSIZE.
- "Accepted" = i_ce high in RUN, or i_ce && i_sync in IDLE.
- IDLE: i_ce && !i_sync -> discard sample, no flag. i_ce && i_sync -> enqueue sample with idx=0, set idx<=1, go to RUN.
- RUN, i_ce && i_sync && idx==0: normal frame start, enqueue, idx<=1.
- RUN, i_ce && !i_sync && idx!=0: enqueue with last = (idx == 2^LGSIZE-1), idx<=idx+1 (wraps to 0).
- RUN, i_ce && i_sync && idx!=0: set o_syncerr. Realign: this sample is index 0, enqueue it, idx<=1. The truncated previous frame gets no o_last.
- RUN, i_ce && !i_sync && idx==0: set o_syncerr, discard sample, go to IDLE.
- Enqueue writes {last, sample}. If the FIFO is full at the start of the cycle, drop the write and set o_overflow. idx and state advance as if the sample had been written, so frame alignment is kept.
- Full is evaluated before this cycle's pop: a pop in the same cycle does not make room.
- Pop when o_valid && i_ready. o_valid = !empty. o_data and o_last show the head entry (first-word fall-through).
- A push and pop in the same cycle when neither full nor empty leaves the count unchanged.
- Sticky flags clear only on reset.
- Pointers are LGFIFO+1 bits. full = MSBs differ and LSBs equal; empty = pointers equal.

## Timing
- Reset (i_areset_n low, asynchronous): state=IDLE, idx=0, FIFO pointers=0, o_valid=0, o_last=0, o_overflow=0, o_syncerr=0. o_data is don't-care.
- Deassertion takes effect on the first rising edge with i_areset_n high.
- Latency: a sample accepted at edge N into an empty FIFO gives o_valid=1 with that data/last during cycle N+1, i.e. sampled at edge N+1.
- o_valid may not drop without a pop, except on reset. o_data and o_last stay stable while o_valid && !i_ready.
- Throughput: one sample per cycle sustained while i_ready is held high; the FIFO never fills.
- Flags rise one edge after the offending input cycle.
- Reset mid-frame discards FIFO contents and the frame in progress.

## Test plan
- LGSIZE=3, i_ready=1, continuous i_ce, i_sync every 8 samples, data 0..15 -> outputs 0..15 in order, o_last on 7 and 15, one-cycle latency, both flags 0.
- Samples 100..102 without sync after reset, then sync on 103 -> 100..102 discarded, first output 103 at idx 0, o_syncerr=0.
- LGSIZE=3, LGFIFO=2, i_ready=0, 6 consecutive samples 0..5 -> FIFO holds 0..3, o_overflow=1 after the 5th. Then raise i_ready -> 0,1,2,3 emitted. Next frame's o_last still lands on index 7.
- Sync on sample 0, then sync again on sample 5 -> o_syncerr=1. Sample 5 emitted as new index 0. o_last appears 7 samples after sample 5.
- RUN at idx 0 with i_ce=1, i_sync=0 -> o_syncerr=1, sample dropped, IDLE until the next sync.
- Pull i_areset_n low asynchronously mid-frame with the FIFO holding 3 entries -> o_valid, o_last, and both flags drop without a clock edge. After release, behaves as from power-up.
